tl_periph_port_buffer: RTL and testbench

TL_PERIPH_PORT_BUFFER -- requirements
Module: tl_periph_port_buffer

---
 rtl/tl_periph_pkg.sv | 26 ++
 rtl/tl_periph_fifo.sv | 46 ++++
 rtl/tl_periph_port_buffer.sv | 137 +++++++++++++
 tb/tb_tl_periph_port_buffer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_periph_pkg.sv
// Shared TL-UL beat types and widths for the peripheral port buffer.
package tl_periph_pkg;
    localparam int TL_ADDR_W = 32;
    localparam int TL_DATA_W = 32;
    localparam int TL_SRC_W  = 1;

    typedef struct packed {
        logic [2:0]             opcode;
        logic [2:0]             param;
        logic [1:0]             size;
        logic [TL_SRC_W-1:0]    source;
        logic [TL_ADDR_W-1:0]   address;
        logic [TL_DATA_W/8-1:0] mask;
        logic [TL_DATA_W-1:0]   data;
    } tl_a_beat_t;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [1:0]           param;
        logic [1:0]           size;
        logic [TL_SRC_W-1:0]  source;
        logic                 denied;
        logic [TL_DATA_W-1:0] data;
        logic                 corrupt;
    } tl_d_beat_t;
endpackage

// File: rtl/tl_periph_fifo.sv
// Count-based FIFO with registered output and no empty bypass.
module tl_periph_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clock,
    input  logic reset,
    input  logic push,
    input  T     push_data,
    output logic full,
    input  logic pop,
    output T     pop_data,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;
    T              mem [DEPTH];

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    // A full queue may still take a beat in the cycle its head leaves.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/tl_periph_port_buffer.sv
// TL-UL A/D buffering in front of the periph bridge with an
// outstanding-request limit.
module tl_periph_port_buffer
    import tl_periph_pkg::*;
#(
    parameter int A_DEPTH      = 2,
    parameter int D_DEPTH      = 2,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_a_valid,
    output logic                 in_a_ready,
    input  logic [2:0]           in_a_opcode,
    input  logic [2:0]           in_a_param,
    input  logic [1:0]           in_a_size,
    input  logic [TL_SRC_W-1:0]  in_a_source,
    input  logic [TL_ADDR_W-1:0] in_a_address,
    input  logic [3:0]           in_a_mask,
    input  logic [TL_DATA_W-1:0] in_a_data,
    output logic                 out_a_valid,
    input  logic                 out_a_ready,
    output logic [2:0]           out_a_opcode,
    output logic [2:0]           out_a_param,
    output logic [1:0]           out_a_size,
    output logic [TL_SRC_W-1:0]  out_a_source,
    output logic [TL_ADDR_W-1:0] out_a_address,
    output logic [3:0]           out_a_mask,
    output logic [TL_DATA_W-1:0] out_a_data,
    input  logic                 out_d_valid,
    output logic                 out_d_ready,
    input  logic [2:0]           out_d_opcode,
    input  logic [1:0]           out_d_param,
    input  logic [1:0]           out_d_size,
    input  logic [TL_SRC_W-1:0]  out_d_source,
    input  logic                 out_d_denied,
    input  logic [TL_DATA_W-1:0] out_d_data,
    input  logic                 out_d_corrupt,
    output logic                 in_d_valid,
    input  logic                 in_d_ready,
    output logic [2:0]           in_d_opcode,
    output logic [1:0]           in_d_param,
    output logic [1:0]           in_d_size,
    output logic [TL_SRC_W-1:0]  in_d_source,
    output logic                 in_d_denied,
    output logic [TL_DATA_W-1:0] in_d_data,
    output logic                 in_d_corrupt,
    output logic [1:0]           inflight,
    output logic                 idle
);
    localparam logic [1:0] MAX_W = 2'(MAX_INFLIGHT);

    tl_a_beat_t a_in;
    tl_a_beat_t a_head;
    tl_d_beat_t d_in;
    tl_d_beat_t d_head;
    logic       a_full, a_empty;
    logic       d_full, d_empty;
    logic       a_fire, oa_fire;
    logic       od_fire, d_fire;
    logic [1:0] inflight_q;

    assign a_in = '{opcode: in_a_opcode, param: in_a_param,
                    size: in_a_size, source: in_a_source,
                    address: in_a_address, mask: in_a_mask,
                    data: in_a_data};
    assign d_in = '{opcode: out_d_opcode, param: out_d_param,
                    size: out_d_size, source: out_d_source,
                    denied: out_d_denied, data: out_d_data,
                    corrupt: out_d_corrupt};

    // inflight already covers beats still waiting in the A queue.
    assign in_a_ready  = !reset && !a_full && (inflight_q < MAX_W);
    assign out_a_valid = !reset && !a_empty;
    assign out_d_ready = !reset && !d_full;
    assign in_d_valid  = !reset && !d_empty;
    assign inflight    = reset ? 2'd0 : inflight_q;
    assign idle        = reset || (a_empty && d_empty && inflight_q == '0);

    assign a_fire  = in_a_valid && in_a_ready;
    assign oa_fire = out_a_valid && out_a_ready;
    assign od_fire = out_d_valid && out_d_ready;
    assign d_fire  = in_d_valid && in_d_ready;

    assign out_a_opcode  = a_head.opcode;
    assign out_a_param   = a_head.param;
    assign out_a_size    = a_head.size;
    assign out_a_source  = a_head.source;
    assign out_a_address = a_head.address;
    assign out_a_mask    = a_head.mask;
    assign out_a_data    = a_head.data;

    assign in_d_opcode  = d_head.opcode;
    assign in_d_param   = d_head.param;
    assign in_d_size    = d_head.size;
    assign in_d_source  = d_head.source;
    assign in_d_denied  = d_head.denied;
    assign in_d_data    = d_head.data;
    assign in_d_corrupt = d_head.corrupt;

    tl_periph_fifo #(.DEPTH(A_DEPTH), .T(tl_a_beat_t)) u_a_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (a_fire),
        .push_data (a_in),
        .full      (a_full),
        .pop       (oa_fire),
        .pop_data  (a_head),
        .empty     (a_empty)
    );

    tl_periph_fifo #(.DEPTH(D_DEPTH), .T(tl_d_beat_t)) u_d_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (od_fire),
        .push_data (d_in),
        .full      (d_full),
        .pop       (d_fire),
        .pop_data  (d_head),
        .empty     (d_empty)
    );

    // A stray D beat with nothing outstanding leaves the count at 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            inflight_q <= '0;
        end else if (a_fire && !d_fire) begin
            inflight_q <= inflight_q + 2'd1;
        end else if (d_fire && !a_fire && inflight_q != '0) begin
            inflight_q <= inflight_q - 2'd1;
        end
    end

    assert property (@(posedge clock) disable iff (reset)
        !(d_fire && inflight_q == '0))
        else $error("in_d beat returned with nothing outstanding");
endmodule

// File: tb/tb_tl_periph_port_buffer.sv
// Bench for tl_periph_port_buffer: queue-level model, bridge model,
// directed scenarios and a random stall soak.
module tb_tl_periph_port_buffer;
    import tl_periph_pkg::*;

    localparam int A_DEPTH = 2;
    localparam int D_DEPTH = 2;
    localparam int MAX_INFLIGHT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_a_valid = 1'b0;
    logic        in_a_ready;
    logic [2:0]  in_a_opcode = '0;
    logic [2:0]  in_a_param = '0;
    logic [1:0]  in_a_size = '0;
    logic [0:0]  in_a_source = '0;
    logic [31:0] in_a_address = '0;
    logic [3:0]  in_a_mask = '0;
    logic [31:0] in_a_data = '0;
    logic        out_a_valid;
    logic        out_a_ready = 1'b0;
    logic [2:0]  out_a_opcode;
    logic [2:0]  out_a_param;
    logic [1:0]  out_a_size;
    logic [0:0]  out_a_source;
    logic [31:0] out_a_address;
    logic [3:0]  out_a_mask;
    logic [31:0] out_a_data;
    logic        out_d_valid = 1'b0;
    logic        out_d_ready;
    logic [2:0]  out_d_opcode = '0;
    logic [1:0]  out_d_param = '0;
    logic [1:0]  out_d_size = '0;
    logic [0:0]  out_d_source = '0;
    logic        out_d_denied = 1'b0;
    logic [31:0] out_d_data = '0;
    logic        out_d_corrupt = 1'b0;
    logic        in_d_valid;
    logic        in_d_ready = 1'b0;
    logic [2:0]  in_d_opcode;
    logic [1:0]  in_d_param;
    logic [1:0]  in_d_size;
    logic [0:0]  in_d_source;
    logic        in_d_denied;
    logic [31:0] in_d_data;
    logic        in_d_corrupt;
    logic [1:0]  inflight;
    logic        idle;

    tl_periph_port_buffer #(
        .A_DEPTH(A_DEPTH), .D_DEPTH(D_DEPTH),
        .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clock(clock), .reset(reset),
        .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
        .in_a_opcode(in_a_opcode), .in_a_param(in_a_param),
        .in_a_size(in_a_size), .in_a_source(in_a_source),
        .in_a_address(in_a_address), .in_a_mask(in_a_mask),
        .in_a_data(in_a_data),
        .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
        .out_a_opcode(out_a_opcode), .out_a_param(out_a_param),
        .out_a_size(out_a_size), .out_a_source(out_a_source),
        .out_a_address(out_a_address), .out_a_mask(out_a_mask),
        .out_a_data(out_a_data),
        .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
        .out_d_opcode(out_d_opcode), .out_d_param(out_d_param),
        .out_d_size(out_d_size), .out_d_source(out_d_source),
        .out_d_denied(out_d_denied), .out_d_data(out_d_data),
        .out_d_corrupt(out_d_corrupt),
        .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
        .in_d_opcode(in_d_opcode), .in_d_param(in_d_param),
        .in_d_size(in_d_size), .in_d_source(in_d_source),
        .in_d_denied(in_d_denied), .in_d_data(in_d_data),
        .in_d_corrupt(in_d_corrupt),
        .inflight(inflight), .idle(idle)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    tl_a_beat_t got_a, in_beat;
    tl_d_beat_t got_d, od_beat;
    assign got_a = {out_a_opcode, out_a_param, out_a_size, out_a_source,
                    out_a_address, out_a_mask, out_a_data};
    assign got_d = {in_d_opcode, in_d_param, in_d_size, in_d_source,
                    in_d_denied, in_d_data, in_d_corrupt};
    assign in_beat = {in_a_opcode, in_a_param, in_a_size, in_a_source,
                      in_a_address, in_a_mask, in_a_data};
    assign od_beat = {out_d_opcode, out_d_param, out_d_size, out_d_source,
                      out_d_denied, out_d_data, out_d_corrupt};

    function automatic tl_a_beat_t mk_a(logic [2:0] op, logic [31:0] addr,
                                        logic [31:0] data);
        tl_a_beat_t b;
        b.opcode = op;
        b.param = '0;
        b.size = 2'd2;
        b.source = addr[4];
        b.address = addr;
        b.mask = 4'hF;
        b.data = data;
        return b;
    endfunction

    // Stimulus knobs and bridge state
    tl_a_beat_t ua_q[$];
    tl_d_beat_t rq[$];
    tl_d_beat_t cap_q[$];
    tl_a_beat_t oa_beat;
    int         oa_mode = 0;
    int         id_mode = 0;
    bit         a_rand = 0, d_rand = 0, soak_on = 0;
    bit         a_fired, oa_fired, od_fired, id_fired;
    int unsigned d_seq = 0;

    // Upstream master and bridge model
    initial forever begin
        tl_a_beat_t nb;
        tl_d_beat_t rb;
        @(posedge clock);
        #1;
        if (in_a_valid && a_fired) in_a_valid = 1'b0;
        if (!in_a_valid) begin
            if (ua_q.size() == 0 && soak_on) begin
                nb = mk_a((($urandom_range(0, 2) == 2) ? 3'd4
                          : 3'($urandom_range(0, 1))),
                          $urandom, $urandom);
                nb.mask = 4'($urandom);
                ua_q.push_back(nb);
            end
            if (ua_q.size() > 0 && (!a_rand || $urandom_range(0, 1) == 1)) begin
                nb = ua_q.pop_front();
                {in_a_opcode, in_a_param, in_a_size, in_a_source,
                 in_a_address, in_a_mask, in_a_data} = nb;
                in_a_valid = 1'b1;
            end
        end
        out_a_ready = (oa_mode == 2) ? 1'($urandom_range(0, 1)) : (oa_mode == 1);
        in_d_ready = (id_mode == 2) ? 1'($urandom_range(0, 1)) : (id_mode == 1);
        if (reset) begin
            rq.delete();
            out_d_valid = 1'b0;
        end else begin
            if (oa_fired) begin
                d_seq++;
                rb.opcode = (oa_beat.opcode == 3'd4) ? 3'd1 : 3'd0;
                rb.param = '0;
                rb.size = oa_beat.size;
                rb.source = oa_beat.source;
                rb.denied = d_rand ? 1'($urandom) : 1'b0;
                rb.data = 32'hA5A5_0000 + d_seq;
                rb.corrupt = d_rand ? 1'($urandom) : 1'b0;
                rq.push_back(rb);
            end
            if (out_d_valid && od_fired) out_d_valid = 1'b0;
            if (!out_d_valid && rq.size() > 0 && (!d_rand || $urandom_range(0, 1) == 1)) begin
                rb = rq.pop_front();
                {out_d_opcode, out_d_param, out_d_size, out_d_source,
                 out_d_denied, out_d_data, out_d_corrupt} = rb;
                out_d_valid = 1'b1;
            end
        end
    end

    // Queue-level model plus per-cycle compare
    tl_a_beat_t aq[$];
    tl_d_beat_t dq[$];
    int  infl = 0;
    int  tot_a = 0;
    bit  both_pend = 0, both_seen = 0;
    logic [1:0] both_infl = '0;

    always @(negedge clock) begin
        bit m_ar, m_dr, af, oaf, odf, idf;
        m_ar = !reset && aq.size() < A_DEPTH && infl < MAX_INFLIGHT;
        m_dr = !reset && dq.size() < D_DEPTH;
        chk("in_a_ready", in_a_ready, m_ar);
        chk("out_d_ready", out_d_ready, m_dr);
        chk("out_a_valid", out_a_valid, !reset && aq.size() > 0);
        chk("in_d_valid", in_d_valid, !reset && dq.size() > 0);
        if (!reset && aq.size() > 0) chk("out_a_beat", got_a, aq[0]);
        if (!reset && dq.size() > 0) chk("in_d_beat", got_d, dq[0]);
        chk("inflight", inflight, reset ? 0 : infl);
        chk("idle", idle, reset || (aq.size() == 0 && dq.size() == 0 && infl == 0));
        chk("inflight_bound", inflight <= MAX_INFLIGHT, 1'b1);

        a_fired = in_a_valid && in_a_ready;
        oa_fired = out_a_valid && out_a_ready;
        od_fired = out_d_valid && out_d_ready;
        id_fired = in_d_valid && in_d_ready;
        oa_beat = got_a;
        if (id_fired) cap_q.push_back(got_d);
        if (both_pend) begin
            both_seen = 1;
            both_infl = inflight;
            both_pend = 0;
        end
        if (a_fired && id_fired && inflight == 2'd1) both_pend = 1;

        if (reset) begin
            aq.delete();
            dq.delete();
            infl = 0;
        end else begin
            af = in_a_valid && m_ar;
            oaf = aq.size() > 0 && out_a_ready;
            odf = out_d_valid && m_dr;
            idf = dq.size() > 0 && in_d_ready;
            if (oaf) void'(aq.pop_front());
            if (af) begin
                aq.push_back(in_beat);
                tot_a++;
            end
            if (idf) void'(dq.pop_front());
            if (odf) dq.push_back(od_beat);
            if (af && !idf) infl++;
            else if (idf && !af && infl > 0) infl--;
        end
    end

    function automatic tl_d_beat_t cap(int i);
        tl_d_beat_t z;
        z = '0;
        if (i < cap_q.size()) return cap_q[i];
        return z;
    endfunction

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_idle", idle, 1'b1);
        chk("rst_a_ready", in_a_ready, 1'b0);
        chk("rst_d_ready", out_d_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_a_ready", in_a_ready, 1'b1);
        chk("post_rst_d_ready", out_d_ready, 1'b1);

        // Single Get through the whole path
        oa_mode = 1;
        id_mode = 1;
        ua_q.push_back(mk_a(3'd4, 32'h1000_0004, 32'h0));
        tick();
        tick();
        chk("get_out_valid", out_a_valid, 1'b1);
        chk("get_out_addr", out_a_address, 32'h1000_0004);
        chk("get_out_size", out_a_size, 2'd2);
        chk("get_out_op", out_a_opcode, 3'd4);
        chk("get_inflight", inflight, 2'd1);
        chk("get_idle", idle, 1'b0);
        repeat (6) tick();
        chk("get_done_inflight", inflight, 2'd0);
        chk("get_done_idle", idle, 1'b1);
        chk("get_d_count", cap_q.size(), 1);
        chk("get_d_data", cap(0).data, 32'hA5A5_0001);
        chk("get_d_op", cap(0).opcode, 3'd1);

        // Inflight limit, D backpressure, ordering
        d_seq = 0;
        cap_q.delete();
        oa_mode = 0;
        id_mode = 0;
        ua_q.push_back(mk_a(3'd0, 32'h100, 32'h11));
        ua_q.push_back(mk_a(3'd0, 32'h104, 32'h22));
        ua_q.push_back(mk_a(3'd0, 32'h108, 32'h33));
        repeat (6) tick();
        chk("lim_a_ready", in_a_ready, 1'b0);
        chk("lim_stall_valid", in_a_valid, 1'b1);
        chk("lim_stall_addr", in_a_address, 32'h108);
        chk("lim_head_addr", out_a_address, 32'h100);
        chk("lim_inflight", inflight, 2'd2);
        oa_mode = 1;
        repeat (8) tick();
        chk("dfull_d_ready", out_d_ready, 1'b0);
        chk("dfull_valid", in_d_valid, 1'b1);
        chk("dfull_head", in_d_data, 32'hA5A5_0001);
        chk("dfull_inflight", inflight, 2'd2);
        id_mode = 1;
        repeat (12) tick();
        chk("order_count", cap_q.size(), 3);
        chk("order_0", cap(0).data, 32'hA5A5_0001);
        chk("order_1", cap(1).data, 32'hA5A5_0002);
        chk("order_2", cap(2).data, 32'hA5A5_0003);
        chk("both_seen", both_seen, 1'b1);
        chk("both_inflight", both_infl, 2'd1);
        chk("order_idle", idle, 1'b1);

        // Reset with beats queued
        d_seq = 0;
        cap_q.delete();
        oa_mode = 0;
        id_mode = 0;
        ua_q.push_back(mk_a(3'd0, 32'h300, 32'h44));
        ua_q.push_back(mk_a(3'd0, 32'h304, 32'h55));
        repeat (5) tick();
        chk("mid_valid", out_a_valid, 1'b1);
        chk("mid_inflight", inflight, 2'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mrst_out_valid", out_a_valid, 1'b0);
        chk("mrst_inflight", inflight, 2'd0);
        chk("mrst_a_ready", in_a_ready, 1'b1);
        ua_q.push_back(mk_a(3'd4, 32'h400, 32'h0));
        oa_mode = 1;
        id_mode = 1;
        repeat (8) tick();
        chk("mrst_d_count", cap_q.size(), 1);
        chk("mrst_d_data", cap(0).data, 32'hA5A5_0001);
        chk("mrst_idle", idle, 1'b1);

        // Random stall soak
        cap_q.delete();
        a_rand = 1;
        d_rand = 1;
        oa_mode = 2;
        id_mode = 2;
        soak_on = 1;
        repeat (10000) tick();
        soak_on = 0;
        d_rand = 0;
        oa_mode = 1;
        id_mode = 1;
        n = 0;
        while (n < 200 && !(idle && !in_a_valid && ua_q.size() == 0 &&
                            rq.size() == 0 && !out_d_valid)) begin
            tick();
            n++;
        end
        chk("drain_timeout", n < 200, 1'b1);
        chk("drain_idle", idle, 1'b1);
        chk("soak_traffic", tot_a > 500, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
